subparser_arg_sequencer: RTL and testbench
==========================================

SUBPARSER_ARG_SEQUENCER -- requirements
Module: subparser_arg_sequencer

Interface
REQ-001 Parameter NUM_ARGS, default 4, number of argument subparsers driven in sequence (legal 1..8).
REQ-002 Parameter STOP_ON_FAIL, default 1, 1 = abort sequence at first failed argument, 0 = run all arguments.
REQ-003 Parameter STOP_ON_NEWLINE, default 1, 1 = abort sequence when an argument reports newline.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 trigger  in  1  start parsing sequence; accepted only when rdy=1.
REQ-007 rdy  out  1  sequencer idle, will accept trigger.
REQ-008 done  out  1  one-cycle pulse, sequence finished.
REQ-009 success  out  1  valid with done; 1 = every executed argument succeeded and none skipped.
REQ-010 newline  out  1  valid with done; 1 = an argument reported newline.
REQ-011 success_mask  out  NUM_ARGS  valid with done; bit i = argument i succeeded.
REQ-012 arg_trigger  out  NUM_ARGS  one-hot trigger pulses to argument subparsers.
REQ-013 arg_done, arg_rdy, arg_rd_trigger, arg_success, arg_newline  in  NUM_ARGS each  per-argument subparser status.
REQ-014 arg_rd_done, arg_rd_rdy, arg_is_empty  out  NUM_ARGS each  per-argument reader responses.
REQ-015 rd_trigger  out  1  to shared reader; rd_done, rd_rdy, is_empty  in  1 each  from shared reader.

Function
REQ-016 FSM states IDLE, LAUNCH, WAIT, ADVANCE, FINISH; index register idx of width clog2(NUM_ARGS) (min 1).
REQ-017 IDLE: rdy=1; trigger=1 -> idx=0, clear success_mask and newline flag, go LAUNCH next cycle.
REQ-018 LAUNCH: wait until arg_rdy[idx]=1, then drive arg_trigger[idx]=1 for exactly one cycle, go WAIT.
REQ-019 WAIT: on arg_done[idx]=1 latch arg_success[idx] into success_mask[idx], OR arg_newline[idx] into newline flag, go ADVANCE.
REQ-020 ADVANCE: go FINISH if idx=NUM_ARGS-1, or (STOP_ON_FAIL and latched success=0), or (STOP_ON_NEWLINE and latched newline=1); else idx+=1, go LAUNCH.
REQ-021 FINISH: done=1 for one cycle with success, newline, success_mask; success = all bits 0..NUM_ARGS-1 of success_mask set; go IDLE.
REQ-022 Minimum latency trigger->done = 4*NUM_ARGS+1 cycles given arg_rdy=1 and arg_done returning the cycle after arg_trigger.
REQ-023 Reader routing combinational: rd_trigger = arg_rd_trigger[idx] only in LAUNCH/WAIT, else 0.
REQ-024 arg_rd_done[i], arg_rd_rdy[i], arg_is_empty[i] = shared inputs when i=idx and state in LAUNCH/WAIT; else 0 (rd_rdy and is_empty also 0) for all non-active i.
REQ-025 arg_rd_trigger from non-active arguments ignored; never forwarded.
REQ-026 trigger while rdy=0 ignored, no effect on sequence.
REQ-027 arg_done for non-active index ignored; arg_done[idx] in same cycle as arg_trigger[idx] not possible to sample (sampled from WAIT only).
REQ-028 NUM_ARGS=1: sequence LAUNCH->WAIT->ADVANCE->FINISH once.
REQ-029 Outputs success, newline, success_mask hold last values between done pulses.

Reset
REQ-030 reset=0 at rising edge -> state IDLE, idx=0, success_mask=0, newline=0, success=0, done=0, arg_trigger=0, rd_trigger=0; rdy=1 from first cycle after release.
REQ-031 Reset mid-sequence aborts without done pulse; routing outputs all 0 while reset asserted.

Structure
REQ-032 Shared parser package holds the state enum typedef and MAX_SUBPARSER_ARGS=8 constant.
REQ-033 One sub-module natural: subparser_reader_mux (combinational per-index reader routing of REQ-023..025).

Verification
REQ-034 NUM_ARGS=4, all succeed, no newline -> arg_trigger pulses 0001,0010,0100,1000 in order; done=1, success=1, success_mask=1111, latency 17 cycles.
REQ-035 STOP_ON_FAIL=1, arg 1 fails -> arg 2/3 never triggered; done with success=0, success_mask=0001.
REQ-036 STOP_ON_FAIL=0, arg 2 fails -> all four triggered; success=0, success_mask=1011.
REQ-037 Arg 1 newline, STOP_ON_NEWLINE=1 -> done after arg 1, newline=1, success_mask=0011, arg 2 untriggered.
REQ-038 Arg 0 issues rd_trigger, reader returns rd_done -> only arg_rd_done[0]=1; rd_trigger from idle arg 3 asserted simultaneously -> rd_trigger unaffected.
REQ-039 reset=0 during WAIT of arg 2 -> no done, rdy=1 after release, new trigger restarts at arg 0.

Source files
------------

// File: rtl/subparser_arg_sequencer_pkg.sv
// Shared definitions for the argument sequencer: FSM state encoding, the
// argument-count ceiling and the index-width helper.
package subparser_arg_sequencer_pkg;

    localparam int MAX_SUBPARSER_ARGS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_FINISH  = 3'd4
    } seq_state_t;

    // Index register width; a single argument still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subparser_reader_mux.sv
// Routes the shared reader to the currently active argument subparser only;
// every other argument sees an idle reader and has its requests dropped.
module subparser_reader_mux #(
    parameter int NUM_ARGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                active,
    input  logic [IDX_W-1:0]    idx,
    input  logic [NUM_ARGS-1:0] arg_rd_trigger,
    input  logic                rd_done,
    input  logic                rd_rdy,
    input  logic                is_empty,
    output logic                rd_trigger,
    output logic [NUM_ARGS-1:0] arg_rd_done,
    output logic [NUM_ARGS-1:0] arg_rd_rdy,
    output logic [NUM_ARGS-1:0] arg_is_empty
);

    logic [NUM_ARGS-1:0] sel;

    generate
        for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_route
            assign sel[gi]          = active && (idx == IDX_W'(gi));
            assign arg_rd_done[gi]  = sel[gi] & rd_done;
            assign arg_rd_rdy[gi]   = sel[gi] & rd_rdy;
            assign arg_is_empty[gi] = sel[gi] & is_empty;
        end
    endgenerate

    assign rd_trigger = |(sel & arg_rd_trigger);

endmodule

// File: rtl/subparser_arg_sequencer.sv
// Drives NUM_ARGS argument subparsers one after another, collecting their
// success/newline status and lending each the shared reader while it runs.
module subparser_arg_sequencer
    import subparser_arg_sequencer_pkg::*;
#(
    parameter int NUM_ARGS        = 4,
    parameter int STOP_ON_FAIL    = 1,
    parameter int STOP_ON_NEWLINE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trigger,
    output logic                rdy,
    output logic                done,
    output logic                success,
    output logic                newline,
    output logic [NUM_ARGS-1:0] success_mask,
    output logic [NUM_ARGS-1:0] arg_trigger,
    input  logic [NUM_ARGS-1:0] arg_done,
    input  logic [NUM_ARGS-1:0] arg_rdy,
    input  logic [NUM_ARGS-1:0] arg_rd_trigger,
    input  logic [NUM_ARGS-1:0] arg_success,
    input  logic [NUM_ARGS-1:0] arg_newline,
    output logic [NUM_ARGS-1:0] arg_rd_done,
    output logic [NUM_ARGS-1:0] arg_rd_rdy,
    output logic [NUM_ARGS-1:0] arg_is_empty,
    output logic                rd_trigger,
    input  logic                rd_done,
    input  logic                rd_rdy,
    input  logic                is_empty
);

    localparam int               IDX_W    = idx_width(NUM_ARGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARGS - 1);

    seq_state_t          state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [NUM_ARGS-1:0] mask_reg;
    logic                nl_reg;
    logic [NUM_ARGS-1:0] arg_trigger_reg;
    logic                success_reg;
    logic                newline_reg;
    logic [NUM_ARGS-1:0] success_mask_reg;

    logic launch_fire;
    logic wait_hit;
    logic stop_now;
    logic route_active;

    assign launch_fire = (state_reg == ST_LAUNCH) && arg_rdy[idx_reg];
    // A done arriving alongside our own trigger pulse cannot belong to this launch.
    assign wait_hit    = (state_reg == ST_WAIT) && arg_done[idx_reg] && !(|arg_trigger_reg);
    assign stop_now    = (idx_reg == LAST_IDX)
                      || ((STOP_ON_FAIL != 0) && !mask_reg[idx_reg])
                      || ((STOP_ON_NEWLINE != 0) && nl_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (trigger) state_next = ST_LAUNCH;
            ST_LAUNCH:  if (launch_fire) state_next = ST_WAIT;
            ST_WAIT:    if (wait_hit) state_next = ST_ADVANCE;
            ST_ADVANCE: state_next = stop_now ? ST_FINISH : ST_LAUNCH;
            ST_FINISH:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rdy          = reset && (state_reg == ST_IDLE);
        done         = reset && (state_reg == ST_FINISH);
        route_active = reset && ((state_reg == ST_LAUNCH) || (state_reg == ST_WAIT));
    end

    // Working mask/flag are cleared per run; the published copies only move at finish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_reg          <= '0;
            mask_reg         <= '0;
            nl_reg           <= 1'b0;
            arg_trigger_reg  <= '0;
            success_reg      <= 1'b0;
            newline_reg      <= 1'b0;
            success_mask_reg <= '0;
        end else begin
            arg_trigger_reg <= launch_fire ? (NUM_ARGS'(1) << idx_reg) : '0;
            if ((state_reg == ST_IDLE) && trigger) begin
                idx_reg  <= '0;
                mask_reg <= '0;
                nl_reg   <= 1'b0;
            end
            if (wait_hit) begin
                mask_reg[idx_reg] <= arg_success[idx_reg];
                nl_reg            <= nl_reg | arg_newline[idx_reg];
            end
            if (state_reg == ST_ADVANCE) begin
                if (stop_now) begin
                    success_reg      <= &mask_reg;
                    newline_reg      <= nl_reg;
                    success_mask_reg <= mask_reg;
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end
        end
    end

    assign arg_trigger  = arg_trigger_reg;
    assign success      = success_reg;
    assign newline      = newline_reg;
    assign success_mask = success_mask_reg;

    subparser_reader_mux #(
        .NUM_ARGS (NUM_ARGS),
        .IDX_W    (IDX_W)
    ) u_reader_mux (
        .active         (route_active),
        .idx            (idx_reg),
        .arg_rd_trigger (arg_rd_trigger),
        .rd_done        (rd_done),
        .rd_rdy         (rd_rdy),
        .is_empty       (is_empty),
        .rd_trigger     (rd_trigger),
        .arg_rd_done    (arg_rd_done),
        .arg_rd_rdy     (arg_rd_rdy),
        .arg_is_empty   (arg_is_empty)
    );

endmodule

// File: tb/tb_subparser_arg_sequencer.sv
// Bench for the argument sequencer: a stopping instance (a_) and a run-all
// instance (b_) share stimulus; results are compared to tables and a model.
module tb_subparser_arg_sequencer;

    logic       clk;
    logic       reset;
    logic       trigger;
    logic [3:0] arg_rdy, arg_rd_trigger, arg_success, arg_newline;
    logic       rd_done, rd_rdy, is_empty;

    logic       a_rdy, a_done, a_success, a_newline, a_rd_trigger;
    logic [3:0] a_success_mask, a_arg_trigger, a_arg_done;
    logic [3:0] a_arg_rd_done, a_arg_rd_rdy, a_arg_is_empty;
    logic       b_rdy, b_done, b_success, b_newline, b_rd_trigger;
    logic [3:0] b_success_mask, b_arg_trigger, b_arg_done;
    logic [3:0] b_arg_rd_done, b_arg_rd_rdy, b_arg_is_empty;

    subparser_arg_sequencer #(.NUM_ARGS(4), .STOP_ON_FAIL(1), .STOP_ON_NEWLINE(1)) dut_a (
        .clk(clk), .reset(reset), .trigger(trigger), .rdy(a_rdy), .done(a_done),
        .success(a_success), .newline(a_newline), .success_mask(a_success_mask),
        .arg_trigger(a_arg_trigger), .arg_done(a_arg_done), .arg_rdy(arg_rdy),
        .arg_rd_trigger(arg_rd_trigger), .arg_success(arg_success), .arg_newline(arg_newline),
        .arg_rd_done(a_arg_rd_done), .arg_rd_rdy(a_arg_rd_rdy), .arg_is_empty(a_arg_is_empty),
        .rd_trigger(a_rd_trigger), .rd_done(rd_done), .rd_rdy(rd_rdy), .is_empty(is_empty)
    );

    subparser_arg_sequencer #(.NUM_ARGS(4), .STOP_ON_FAIL(0), .STOP_ON_NEWLINE(0)) dut_b (
        .clk(clk), .reset(reset), .trigger(trigger), .rdy(b_rdy), .done(b_done),
        .success(b_success), .newline(b_newline), .success_mask(b_success_mask),
        .arg_trigger(b_arg_trigger), .arg_done(b_arg_done), .arg_rdy(arg_rdy),
        .arg_rd_trigger(arg_rd_trigger), .arg_success(arg_success), .arg_newline(arg_newline),
        .arg_rd_done(b_arg_rd_done), .arg_rd_rdy(b_arg_rd_rdy), .arg_is_empty(b_arg_is_empty),
        .rd_trigger(b_rd_trigger), .rd_done(rd_done), .rd_rdy(rd_rdy), .is_empty(is_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Argument subparsers answer the cycle after their trigger pulse.
    always @(posedge clk) begin
        a_arg_done <= reset ? a_arg_trigger : 4'h0;
        b_arg_done <= reset ? b_arg_trigger : 4'h0;
    end

    typedef struct {
        int         lat;
        int         ndone;
        logic [3:0] mask;
        logic [3:0] trig;
        logic [3:0] last;
        logic       succ;
        logic       nl;
        bit         order_bad;
    } res_t;

    typedef struct {
        logic [3:0] s, nl;
        logic [3:0] a_mask, a_trig; logic a_succ, a_nl; int a_lat;
        logic [3:0] b_mask, b_trig; logic b_succ, b_nl; int b_lat;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: walk the arguments in order and stop where the policy says so.
    task automatic model(input logic [3:0] s, input logic [3:0] nl, input bit sof, input bit son,
                         output logic [3:0] mask, output logic [3:0] trig,
                         output logic succ, output logic nlo, output int lat);
        mask = 4'h0; trig = 4'h0; nlo = 1'b0; lat = 1;
        for (int i = 0; i < 4; i++) begin
            trig[i] = 1'b1;
            mask[i] = s[i];
            nlo     = nlo | nl[i];
            lat     = lat + 4;
            if ((sof && !s[i]) || (son && nl[i])) break;
        end
        succ = (mask == 4'hF);
    endtask

    task automatic obs(inout res_t r, input int k, input logic d, input logic s, input logic n,
                       input logic [3:0] m, input logic [3:0] t);
        if (t != 4'h0) begin
            if ($countones(t) != 1 || t <= r.last) r.order_bad = 1'b1;
            r.trig = r.trig | t;
            r.last = t;
        end
        if (d) begin
            r.ndone++;
            if (r.ndone == 1) begin
                r.lat = k; r.mask = m; r.succ = s; r.nl = n;
            end
        end
    endtask

    task automatic run_seq(input logic [3:0] s, input logic [3:0] nl, input int retrig_k,
                           input int rdy_rel_k, output res_t ra, output res_t rb);
        ra = '{default: '0};
        rb = '{default: '0};
        arg_success = s;
        arg_newline = nl;
        arg_rdy     = (rdy_rel_k > 0) ? 4'h0 : 4'hF;
        chk("rdy_before_a", {31'd0, a_rdy}, 32'd1);
        trigger = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            trigger = (k == retrig_k);
            if (k == rdy_rel_k) arg_rdy = 4'hF;
            obs(ra, k, a_done, a_success, a_newline, a_success_mask, a_arg_trigger);
            obs(rb, k, b_done, b_success, b_newline, b_success_mask, b_arg_trigger);
        end
        trigger = 1'b0;
    endtask

    task automatic check_res(input string tag, input res_t r, input logic [3:0] mask,
                             input logic [3:0] trig, input logic succ, input logic nl, input int lat);
        $display("txn %s: mask=%b trig=%b succ=%b nl=%b lat=%0d dones=%0d",
                 tag, r.mask, r.trig, r.succ, r.nl, r.lat, r.ndone);
        chk({tag, "_mask"}, {28'd0, r.mask}, {28'd0, mask});
        chk({tag, "_trig"}, {28'd0, r.trig}, {28'd0, trig});
        chk({tag, "_succ"}, {31'd0, r.succ}, {31'd0, succ});
        chk({tag, "_nl"},   {31'd0, r.nl},   {31'd0, nl});
        chk({tag, "_lat"},  r.lat, lat);
        chk({tag, "_ndone"}, r.ndone, 1);
        chk({tag, "_order"}, {31'd0, r.order_bad}, 32'd0);
    endtask

    vec_t vecs[5];
    res_t ra, rb;
    logic [3:0] em, et;
    logic es, en;
    int el, cnt;

    initial begin
        vecs[0] = '{4'hF, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 17, 4'hF, 4'hF, 1'b1, 1'b0, 17};
        vecs[1] = '{4'hD, 4'h0, 4'h1, 4'h3, 1'b0, 1'b0,  9, 4'hD, 4'hF, 1'b0, 1'b0, 17};
        vecs[2] = '{4'hB, 4'h0, 4'h3, 4'h7, 1'b0, 1'b0, 13, 4'hB, 4'hF, 1'b0, 1'b0, 17};
        vecs[3] = '{4'hF, 4'h2, 4'h3, 4'h3, 1'b0, 1'b1,  9, 4'hF, 4'hF, 1'b1, 1'b1, 17};
        vecs[4] = '{4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0,  5, 4'h0, 4'hF, 1'b0, 1'b0, 17};

        // Reset with the reader lines all driven high: nothing may leak through.
        reset = 1'b0; trigger = 1'b0; arg_rdy = 4'hF; arg_success = 4'h0; arg_newline = 4'h0;
        arg_rd_trigger = 4'hF; rd_done = 1'b1; rd_rdy = 1'b1; is_empty = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_done",     {31'd0, a_done}, 32'd0);
        chk("rst_success",  {31'd0, a_success}, 32'd0);
        chk("rst_newline",  {31'd0, a_newline}, 32'd0);
        chk("rst_mask",     {28'd0, a_success_mask}, 32'd0);
        chk("rst_arg_trig", {28'd0, a_arg_trigger}, 32'd0);
        chk("rst_rd_trig",  {31'd0, a_rd_trigger}, 32'd0);
        chk("rst_rd_done",  {28'd0, a_arg_rd_done}, 32'd0);
        chk("rst_rd_rdy",   {28'd0, a_arg_rd_rdy | a_arg_is_empty}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {31'd0, a_rdy}, 32'd1);
        chk("idle_rd_trig",  {31'd0, a_rd_trigger}, 32'd0);
        arg_rd_trigger = 4'h0; rd_done = 1'b0; rd_rdy = 1'b0; is_empty = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].s, vecs[v].nl, 0, 0, ra, rb);
            check_res($sformatf("vec%0d_a", v), ra, vecs[v].a_mask, vecs[v].a_trig,
                      vecs[v].a_succ, vecs[v].a_nl, vecs[v].a_lat);
            check_res($sformatf("vec%0d_b", v), rb, vecs[v].b_mask, vecs[v].b_trig,
                      vecs[v].b_succ, vecs[v].b_nl, vecs[v].b_lat);
        end
        chk("hold_mask_a", {28'd0, a_success_mask}, 32'd0);
        chk("hold_mask_b", {28'd0, b_success_mask}, 32'd0);

        // Extra trigger mid-run must be ignored.
        run_seq(4'hF, 4'h0, 5, 0, ra, rb);
        check_res("retrig_a", ra, 4'hF, 4'hF, 1'b1, 1'b0, 17);

        // arg_rdy held low until cycle 6 stretches latency by 5.
        run_seq(4'hF, 4'h0, 0, 6, ra, rb);
        check_res("stall_a", ra, 4'hF, 4'hF, 1'b1, 1'b0, 22);

        // Reader routing while stalled in launch of arg 0.
        arg_rdy = 4'h0; arg_success = 4'hF; arg_newline = 4'h0;
        trigger = 1'b1; @(negedge clk); trigger = 1'b0;
        arg_rd_trigger = 4'b1001; #1;
        chk("route_trig_arg0", {31'd0, a_rd_trigger}, 32'd1);
        arg_rd_trigger = 4'b1000; #1;
        chk("route_trig_idle3", {31'd0, a_rd_trigger}, 32'd0);
        arg_rd_trigger = 4'h0; rd_done = 1'b1; rd_rdy = 1'b1; is_empty = 1'b1; #1;
        chk("route_rd_done", {28'd0, a_arg_rd_done}, 32'd1);
        chk("route_rd_rdy",  {28'd0, a_arg_rd_rdy}, 32'd1);
        chk("route_empty",   {28'd0, a_arg_is_empty}, 32'd1);
        chk("route_no_launch", {28'd0, a_arg_trigger}, 32'd0);
        rd_done = 1'b0; rd_rdy = 1'b0; is_empty = 1'b0; arg_rdy = 4'hF;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_done) cnt++;
        end
        chk("route_finish", cnt, 1);
        $display("txn route: a dones=%0d", cnt);

        // Reset during the wait of arg 2 aborts silently.
        trigger = 1'b1; @(negedge clk); trigger = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_at_arg2", {28'd0, a_arg_trigger}, 32'h4);
        reset = 1'b0; rd_done = 1'b1; rd_rdy = 1'b1; is_empty = 1'b1; arg_rd_trigger = 4'hF;
        @(negedge clk);
        chk("abort_rd_trig",  {31'd0, a_rd_trigger}, 32'd0);
        chk("abort_rd_route", {28'd0, a_arg_rd_done | a_arg_rd_rdy | a_arg_is_empty}, 32'd0);
        reset = 1'b1; rd_done = 1'b0; rd_rdy = 1'b0; is_empty = 1'b0; arg_rd_trigger = 4'h0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_done || b_done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        $display("txn abort: dones after reset=%0d", cnt);
        run_seq(4'hF, 4'h0, 0, 0, ra, rb);
        check_res("restart_a", ra, 4'hF, 4'hF, 1'b1, 1'b0, 17);

        // Randomized argument outcomes against the reference walk.
        for (int it = 0; it < 24; it++) begin
            logic [3:0] s, nl;
            s  = 4'($urandom);
            nl = 4'($urandom & $urandom & $urandom);
            run_seq(s, nl, 0, 0, ra, rb);
            model(s, nl, 1'b1, 1'b1, em, et, es, en, el);
            check_res($sformatf("rnd%0d_a", it), ra, em, et, es, en, el);
            model(s, nl, 1'b0, 1'b0, em, et, es, en, el);
            check_res($sformatf("rnd%0d_b", it), rb, em, et, es, en, el);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
